inspector_stat_sched: RTL
=========================

// Module: inspector_stat_sched
// PURPOSE
//  Snapshot scheduler for the inspector counter bank. It drives the 4-bit counter-select
//  mux, samples each 8-bit counter in turn and streams one frame out over a valid/ready
//  byte interface toward a UART/host bridge.
//  Sits between the counter-select mux (sel -> counts) and the host-link serializer.
// PARAMETERS
//  PERIOD   32'd100_000_000  auto-snapshot interval in clk cycles; 0 = auto trigger off
//  HDR_BYTE 8'hA5            frame start byte
//  NSEL     4'd15            last select index scanned (scan runs 1..NSEL)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  snap       in   1  manual snapshot request, one-cycle pulse
//  sel        out  4  counter-mux select (0 = idle, mux returns 8'hFF)
//  counts     in   8  mux output for current sel (combinational from sel)
//  out_data   out  8  frame byte
//  out_valid  out  1  out_data valid
//  out_ready  in   1  sink accepts byte when out_valid&&out_ready
//  busy       out  1  frame in progress (state != IDLE)
//  ovr_cnt    out  8  dropped-trigger count, saturates at 8'hFF
// BEHAVIOUR
//  Reset: sel=0, out_data=0, out_valid=0, busy=0, ovr_cnt=0, timer=0, pending=0, state=IDLE.
//   An async reset mid-frame drops out_valid immediately; the partial frame is abandoned.
//  Trigger = snap | (PERIOD!=0 && timer==PERIOD-1). The timer free-runs and wraps to 0
//   on the cycle it fires; it counts whether or not a frame is in progress.
//  FSM: IDLE -> HDR -> SEL -> LOAD -> SEND -> (SEL | CSUM | IDLE)
//   IDLE: on trigger (or pending=1) go to HDR; clear pending; idx<=1; csum<=0.
//   HDR : out_valid=1, out_data=HDR_BYTE; on accept go to SEL.
//   SEL : sel<=idx (registered); out_valid=0.
//   LOAD: out_data<=counts, captured one cycle after sel changes; csum<=csum^counts.
//   SEND: out_valid=1, out_data held stable until accept. On accept: if idx==NSEL, go to
//         CSUM (macro set) or IDLE with sel<=0; else idx<=idx+1 and go to SEL.
//   CSUM: out_valid=1, out_data=csum; on accept go to IDLE, sel<=0.
//  Handshake: out_valid never drops and out_data never changes before accept.
//   out_ready is ignored while out_valid=0.
//  Frame timing with out_ready tied high: HDR is 1 cycle, then 3 cycles per counter.
//   NSEL=15 gives 46 cycles, +1 for CSUM. busy deasserts the cycle after the last accept.
//  Trigger while busy: set pending=1 if pending=0, else ovr_cnt<=sat(ovr_cnt+1).
//   Two simultaneous sources (snap and timer) in the same cycle count as one trigger.
//   Pending starts the next frame from IDLE with no idle gap beyond the IDLE cycle.
//  Trigger in IDLE while pending=1: treated as a single start. No overrun is counted.
//  counts is only sampled in LOAD, so counter updates elsewhere in a frame are not glitches.
// CONFIGURATION
//  STAT_CSUM_EN defined: the frame ends with CSUM, the XOR of the NSEL counter bytes
//   (the header is excluded). Frame = 1+NSEL+1 bytes.
//  STAT_CSUM_EN undefined: no CSUM state and no csum register; frame = 1+NSEL bytes,
//   and SEND on idx==NSEL goes straight to IDLE.
// STRUCTURE
//  Package inspector_stat_pkg: state enum (IDLE,HDR,SEL,LOAD,SEND,CSUM), SEL_IDLE=4'h0,
//   default HDR_BYTE, frame-length constant.
//  One sub-module, stat_period_timer: PERIOD counter with a fire pulse, disabled when
//   PERIOD=0. The FSM, index, capture and overrun logic stay in the top module.
// TESTING (mock mux: counts = {sel,sel} when sel!=0, else 8'hFF; PERIOD=0 unless stated)
//  1 snap pulse, out_ready=1 -> bytes A5,11,22,...,FF in 46 cycles, sel back to 0;
//    with STAT_CSUM_EN a 17th byte equals the XOR of 11..FF.
//  2 out_ready toggled randomly -> same byte sequence, out_data stable while valid&&!ready,
//    no byte lost or duplicated.
//  3 snap mid-frame, then two more snaps mid-frame -> second frame follows immediately
//    after the first; ovr_cnt=2.
//  4 rst_n low during the 5th counter byte -> out_valid=0, sel=0 and busy=0 at once;
//    next snap gives a full frame.
//  5 PERIOD=100, out_ready=1 -> frame starts every 100 cycles; ovr_cnt stays 0.
//    With out_ready=0 for 300 cycles, ovr_cnt increments per dropped fire and
//    saturates at FF over a long run.
//  6 snap and timer fire in the same cycle in IDLE -> exactly one frame, ovr_cnt unchanged.

Source files
------------

// File: rtl/inspector_stat_sched_pkg.sv
// inspector_stat_pkg: shared types and constants for the inspector snapshot scheduler.
//   state_t          FSM state encoding (IDLE, HDR, SEL, LOAD, SEND, CSUM)
//   SEL_IDLE         mux select value that parks the counter mux (returns 8'hFF)
//   HDR_BYTE_DEFAULT default frame start byte
//   NSEL_DEFAULT     default last select index scanned
//   frame_len()      bytes per frame for a given NSEL
// Config macro: STAT_CSUM_EN adds a trailing XOR checksum byte to each frame.
package inspector_stat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEL,
    LOAD,
    SEND,
    CSUM
  } state_t;

  localparam logic [3:0] SEL_IDLE         = 4'h0;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam logic [3:0] NSEL_DEFAULT     = 4'd15;

`ifdef STAT_CSUM_EN
  localparam int unsigned FRAME_TRAILER = 1;
`else
  localparam int unsigned FRAME_TRAILER = 0;
`endif

  // Header + one byte per scanned counter + optional checksum.
  function automatic int unsigned frame_len(input logic [3:0] nsel);
    return 32'd1 + 32'(nsel) + FRAME_TRAILER;
  endfunction

endpackage

// File: rtl/inspector_stat_sched_if.sv
// inspector_stat_sched_if: valid/ready byte stream from the scheduler to the host link.
//   out_data   frame byte
//   out_valid  out_data valid
//   out_ready  sink accepts the byte when out_valid && out_ready
// Modports: master (scheduler side), slave (host-link side).
interface inspector_stat_sched_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/inspector_stat_sched_timer.sv
// stat_period_timer: free-running auto-snapshot timer.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   fire   one-cycle pulse when the timer reaches PERIOD-1; it wraps to 0 on that cycle
// PERIOD = 0 disables the timer: it holds at 0 and never fires.
module stat_period_timer #(
  parameter logic [31:0] PERIOD = 32'd100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic fire
);

  logic [31:0] timer;

  assign fire = (PERIOD != 32'd0) && (timer == PERIOD - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (PERIOD == 32'd0 || fire) begin
      timer <= '0;
    end else begin
      timer <= timer + 32'd1;
    end
  end

endmodule

// File: rtl/inspector_stat_sched.sv
// inspector_stat_sched: snapshot scheduler for the inspector counter bank.
// Scans counter-mux selects 1..NSEL, captures each 8-bit count and streams a frame
// (HDR_BYTE, count[1..NSEL] [, XOR checksum]) over a valid/ready byte link.
//   clk      system clock
//   rst_n    asynchronous active-low reset (abandons any partial frame)
//   snap     manual snapshot request pulse
//   sel      counter-mux select, 0 while idle
//   counts   mux output for the current sel
//   link     byte stream (out_data/out_valid/out_ready), master side
//   busy     frame in progress
//   ovr_cnt  dropped-trigger count, saturating
// Config macro: STAT_CSUM_EN appends the XOR of the counter bytes as a final byte.
module inspector_stat_sched
  import inspector_stat_pkg::*;
#(
  parameter logic [31:0] PERIOD   = 32'd100_000_000,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT,
  parameter logic [3:0]  NSEL     = NSEL_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          snap,
  output logic [3:0]                    sel,
  input  logic [7:0]                    counts,
  inspector_stat_sched_if.master        link,
  output logic                          busy,
  output logic [7:0]                    ovr_cnt
);

  state_t     state;
  logic [3:0] idx;
  logic       pending;
  logic       fire;
  logic       trigger;
  logic       accept;
`ifdef STAT_CSUM_EN
  logic [7:0] csum;
`endif

  stat_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .fire  (fire)
  );

  // snap and timer in the same cycle collapse into a single trigger.
  assign trigger = snap | fire;
  assign accept  = link.out_valid & link.out_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sel            <= SEL_IDLE;
      idx            <= 4'd1;
      pending        <= 1'b0;
      ovr_cnt        <= '0;
      link.out_data  <= '0;
      link.out_valid <= 1'b0;
`ifdef STAT_CSUM_EN
      csum           <= '0;
`endif
    end else begin
      // One trigger may queue behind a running frame; further ones are dropped and counted.
      if (state != IDLE && trigger) begin
        if (!pending) begin
          pending <= 1'b1;
        end else if (ovr_cnt != '1) begin
          ovr_cnt <= ovr_cnt + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if (trigger || pending) begin
            state          <= HDR;
            pending        <= 1'b0;
            idx            <= 4'd1;
            link.out_valid <= 1'b1;
            link.out_data  <= HDR_BYTE;
`ifdef STAT_CSUM_EN
            csum           <= '0;
`endif
          end
        end
        HDR: begin
          if (accept) begin
            link.out_valid <= 1'b0;
            state          <= SEL;
          end
        end
        SEL: begin
          sel            <= idx;
          link.out_valid <= 1'b0;
          state          <= LOAD;
        end
        LOAD: begin
          // sel was registered last cycle, so counts now reflects the new select.
          link.out_data  <= counts;
          link.out_valid <= 1'b1;
`ifdef STAT_CSUM_EN
          csum           <= csum ^ counts;
`endif
          state          <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (idx == NSEL) begin
`ifdef STAT_CSUM_EN
              link.out_data  <= csum;
              state          <= CSUM;
`else
              link.out_valid <= 1'b0;
              sel            <= SEL_IDLE;
              state          <= IDLE;
`endif
            end else begin
              idx            <= idx + 4'd1;
              link.out_valid <= 1'b0;
              state          <= SEL;
            end
          end
        end
`ifdef STAT_CSUM_EN
        CSUM: begin
          if (accept) begin
            link.out_valid <= 1'b0;
            sel            <= SEL_IDLE;
            state          <= IDLE;
          end
        end
`endif
        default: begin
          link.out_valid <= 1'b0;
          sel            <= SEL_IDLE;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
